pixel_row_loader: RTL and testbench
===================================

Name: pixel_row_loader

Overview:
Fabric-side consumer of the HPS pixel PIO exports: pixel_data, pixel_index_in_row, pixel_row, pixel_status_read and pixel_status_write.
- Requests one image row at a time from HPS software.
- Accepts pixels over a four-phase status handshake.
- Fills the back half of a ping-pong line buffer.
- Serves the front half to the downstream VGA timing/scan-out stage.
- Sits between the HPS system's PIO exports and the VGA output stage.

Parameters:
H_PIXELS, 640, pixels per row; accepted index range is 0..H_PIXELS-1.
V_ROWS, 480, rows per frame; the row counter wraps at this value.
IDX_W, 10, width of line-buffer address and pixel count (must satisfy 2**IDX_W >= H_PIXELS).
PIXEL_W, 24, pixel width as RGB888.

Ports:
clk_clk  in  1  system clock, same clock as the HPS PIO domain
reset_reset  in  1  asynchronous, active-high reset
pio_pixel_data  in  24  pixel value written by HPS (pixel_data_export)
pio_pixel_index  in  16  pixel column written by HPS (pixel_index_in_row_export)
pio_status_write  in  4  HPS control: [0] VALID, [3] CLR_ERR, [2:1] reserved and ignored
pio_pixel_row  out  16  row number requested from HPS (pixel_row_export)
pio_status_read  out  4  to HPS: [0] ACK, [1] ROW_REQ, [2] UNDERRUN (sticky), [3] BAD_INDEX (sticky)
frame_start  in  1  one-cycle pulse from VGA stage at vertical blank: restart at row 0
line_swap  in  1  one-cycle pulse from VGA stage at end of displayed line
rd_addr  in  IDX_W  scan-out read address into the front buffer
rd_data  out  PIXEL_W  front-buffer pixel; 1-cycle registered latency
row_ready  out  1  back buffer holds a complete row

Behaviour:
- Reset: every output is 0. State is IDLE; row, count and front-buffer select are 0; all sticky bits are cleared. Buffer RAM contents are undefined.
- States: IDLE, REQ, WAIT_VALID, ACK_WAIT, FULL.
- IDLE: waits for frame_start, then sets row=0, count=0 and goes to REQ.
- REQ (1 cycle): drives pio_pixel_row=row and sets ROW_REQ=1, then goes to WAIT_VALID.
- WAIT_VALID: on VALID=1, it handles the pixel, sets ACK=1 and goes to ACK_WAIT.
  - If index < H_PIXELS: writes pio_pixel_data to back[index] and increments count.
  - Otherwise: discards the data and sets BAD_INDEX.
- ACK_WAIT: holds ACK=1 until VALID=0, then clears ACK in that same cycle.
  - If count == H_PIXELS: goes to FULL with ROW_REQ=0 and row_ready=1.
  - Otherwise: returns to WAIT_VALID.
- Count rule: count tracks accepted writes, including duplicate indices. Software is responsible for writing each index exactly once.
- FULL: on line_swap, it toggles the front/back select, advances row (wrapping V_ROWS-1 -> 0), clears count and row_ready, and goes to REQ.
- line_swap outside FULL: sets UNDERRUN sticky. Select is not toggled, so the front row is repeated. The load in progress continues.
- frame_start: recorded as pending, then serviced as follows.
  - Serviced in IDLE, REQ, WAIT_VALID or FULL on the next cycle, and in ACK_WAIT only after VALID=0 and ACK drops. An in-flight handshake is never abandoned.
  - Service action: row=0, count=0, row_ready=0, select unchanged, go to REQ.
  - frame_start and line_swap in the same cycle: frame_start wins and line_swap is ignored (no UNDERRUN).
- CLR_ERR=1 in any cycle clears UNDERRUN and BAD_INDEX. If a set event occurs in the same cycle, the set wins.
- ACK and ROW_REQ are registered, so changes appear the cycle after the causing condition.
- rd_data is registered from front[rd_addr]. rd_addr >= H_PIXELS reads 0. Reads during a swap cycle use the pre-swap select.
- Asynchronous reset mid-load returns to IDLE immediately and clears ACK. HPS software must restart on frame_start.

Decomposition:
- Package vga_viewer_pkg holds: the state enum; status bit positions (ST_VALID=0, ST_CLR_ERR=3, SR_ACK=0, SR_ROW_REQ=1, SR_UNDERRUN=2, SR_BAD_INDEX=3); and default H_PIXELS/V_ROWS/PIXEL_W.
- Sub-module pingpong_line_buffer: two simple dual-port RAMs of H_PIXELS x PIXEL_W, with one write port to the back half, one registered read port from the front half, and a select toggle input.

Test Plan:
1. Reset, frame_start -> within 2 cycles pio_pixel_row=0 and status_read=4'b0010. A single write (idx 5, data 24'hFF0000) gives ACK=1 the cycle after VALID; VALID dropped gives ACK=0 the next cycle.
2. Full row 0 with 640 writes (data = idx) -> row_ready=1, ROW_REQ=0. line_swap -> pio_pixel_row=1, ROW_REQ=1. rd_addr=37 returns 24'h000025 one cycle later.
3. line_swap while row 1 has only 100 pixels -> UNDERRUN=1, front still row 0 (rd_addr=37 returns 24'h000025). CLR_ERR pulse -> UNDERRUN=0.
4. Write with index 700 -> ACK still given, BAD_INDEX=1, count unchanged (row completes only after 640 valid writes).
5. frame_start pulsed while VALID=1/ACK=1 -> ACK stays 1 until VALID drops. The next cycle after ACK clears: pio_pixel_row=0, count restarted. Rows 479 -> line_swap gives row 0.
6. Assert reset_reset mid-handshake -> all outputs 0 asynchronously, state IDLE, no ROW_REQ until the next frame_start.

Source files
------------

// File: rtl/vga_viewer_pkg.sv
// rtl/vga_viewer_pkg.sv - shared state type, status bit positions and defaults for the pixel row loader
package vga_viewer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_VALID,
        S_ACK_WAIT,
        S_FULL
    } state_e;

    // pio_status_write bits (from HPS)
    localparam int ST_VALID     = 0;
    localparam int ST_CLR_ERR   = 3;

    // pio_status_read bits (to HPS)
    localparam int SR_ACK       = 0;
    localparam int SR_ROW_REQ   = 1;
    localparam int SR_UNDERRUN  = 2;
    localparam int SR_BAD_INDEX = 3;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_ROWS   = 480;
    localparam int DEF_PIXEL_W  = 24;

endpackage

// File: rtl/pingpong_line_buffer.sv
// rtl/pingpong_line_buffer.sv - two-bank line buffer: write into the back bank, registered read from the front bank
module pingpong_line_buffer
    import vga_viewer_pkg::*;
#(
    parameter int DEPTH  = DEF_H_PIXELS,
    parameter int ADDR_W = 10,
    parameter int DATA_W = DEF_PIXEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    logic              sel_q, sel_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // sel_q selects the front bank; the swap takes effect after this cycle's read
    always_comb begin
        sel_d     = sel_q ^ swap;
        rd_data_d = '0;
        if (rd_addr <= LAST_ADDR) begin
            rd_data_d = sel_q ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (sel_q) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            sel_q     <= sel_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_row_loader.sv
// rtl/pixel_row_loader.sv - requests rows from HPS over the PIO status handshake and fills a ping-pong line buffer
module pixel_row_loader
    import vga_viewer_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_ROWS   = DEF_V_ROWS,
    parameter int IDX_W    = 10,
    parameter int PIXEL_W  = DEF_PIXEL_W
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [PIXEL_W-1:0] pio_pixel_data,
    input  logic [15:0]        pio_pixel_index,
    input  logic [3:0]         pio_status_write,
    output logic [15:0]        pio_pixel_row,
    output logic [3:0]         pio_status_read,
    input  logic               frame_start,
    input  logic               line_swap,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               row_ready
);

    localparam logic [15:0]    IDX_LIMIT  = 16'(H_PIXELS);
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(H_PIXELS);
    localparam logic [15:0]    LAST_ROW   = 16'(V_ROWS - 1);

    state_e         state_q, state_d;
    logic [15:0]    row_q, row_d;
    logic [15:0]    pixel_row_q, pixel_row_d;
    logic [IDX_W:0] count_q, count_d;
    logic           ack_q, ack_d;
    logic           row_req_q, row_req_d;
    logic           row_ready_q, row_ready_d;
    logic           underrun_q, underrun_d;
    logic           bad_index_q, bad_index_d;
    logic           fs_pend_q, fs_pend_d;

    logic valid, clr_err, service, wr_en, swap, underrun_set, bad_set;
    logic [1:0] unused_status_bits;

    assign valid              = pio_status_write[ST_VALID];
    assign clr_err            = pio_status_write[ST_CLR_ERR];
    assign unused_status_bits = pio_status_write[2:1];

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        pixel_row_d  = pixel_row_q;
        count_d      = count_q;
        ack_d        = ack_q;
        row_req_d    = row_req_q;
        row_ready_d  = row_ready_q;
        fs_pend_d    = fs_pend_q | frame_start;
        wr_en        = 1'b0;
        swap         = 1'b0;
        bad_set      = 1'b0;
        underrun_set = line_swap && !frame_start && (state_q != S_FULL);
        // an in-flight handshake must finish before a frame restart is taken
        service      = fs_pend_d && ((state_q != S_ACK_WAIT) || !valid);

        case (state_q)
            S_IDLE: ;
            S_REQ: begin
                pixel_row_d = row_q;
                row_req_d   = 1'b1;
                state_d     = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (valid) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK_WAIT;
                    if (pio_pixel_index < IDX_LIMIT) begin
                        wr_en   = 1'b1;
                        count_d = count_q + (IDX_W + 1)'(1);
                    end else begin
                        bad_set = 1'b1;
                    end
                end
            end
            S_ACK_WAIT: begin
                if (!valid) begin
                    ack_d = 1'b0;
                    if (count_q == FULL_COUNT) begin
                        row_req_d   = 1'b0;
                        row_ready_d = 1'b1;
                        state_d     = S_FULL;
                    end else begin
                        state_d = S_WAIT_VALID;
                    end
                end
            end
            S_FULL: begin
                if (line_swap) begin
                    swap        = 1'b1;
                    row_d       = (row_q == LAST_ROW) ? 16'd0 : row_q + 16'd1;
                    count_d     = '0;
                    row_ready_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (service) begin
            state_d      = S_REQ;
            row_d        = '0;
            count_d      = '0;
            row_ready_d  = 1'b0;
            ack_d        = 1'b0;
            wr_en        = 1'b0;
            swap         = 1'b0;
            bad_set      = 1'b0;
            fs_pend_d    = 1'b0;
        end

        underrun_d  = underrun_set | (underrun_q & ~clr_err);
        bad_index_d = bad_set | (bad_index_q & ~clr_err);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            pixel_row_q <= '0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            row_req_q   <= 1'b0;
            row_ready_q <= 1'b0;
            underrun_q  <= 1'b0;
            bad_index_q <= 1'b0;
            fs_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pixel_row_q <= pixel_row_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            row_req_q   <= row_req_d;
            row_ready_q <= row_ready_d;
            underrun_q  <= underrun_d;
            bad_index_q <= bad_index_d;
            fs_pend_q   <= fs_pend_d;
        end
    end

    always_comb begin
        pio_status_read               = '0;
        pio_status_read[SR_ACK]       = ack_q;
        pio_status_read[SR_ROW_REQ]   = row_req_q;
        pio_status_read[SR_UNDERRUN]  = underrun_q;
        pio_status_read[SR_BAD_INDEX] = bad_index_q;
    end

    assign pio_pixel_row = pixel_row_q;
    assign row_ready     = row_ready_q;

    pingpong_line_buffer #(
        .DEPTH  (H_PIXELS),
        .ADDR_W (IDX_W),
        .DATA_W (PIXEL_W)
    ) u_buf (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .swap    (swap),
        .wr_en   (wr_en),
        .wr_addr (pio_pixel_index[IDX_W-1:0]),
        .wr_data (pio_pixel_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pixel_row_loader.sv
// tb/tb_pixel_row_loader.sv - directed bench for pixel_row_loader (row wrap exercised with a 4-row frame)
module tb_pixel_row_loader;

    localparam int TB_ROWS = 4;

    logic        clk;
    logic        rst;
    logic [23:0] pio_pixel_data;
    logic [15:0] pio_pixel_index;
    logic [3:0]  pio_status_write;
    logic [15:0] pio_pixel_row;
    logic [3:0]  pio_status_read;
    logic        frame_start;
    logic        line_swap;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic        row_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [23:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab [7];

    pixel_row_loader #(
        .V_ROWS (TB_ROWS)
    ) dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .pio_pixel_data   (pio_pixel_data),
        .pio_pixel_index  (pio_pixel_index),
        .pio_status_write (pio_status_write),
        .pio_pixel_row    (pio_pixel_row),
        .pio_status_read  (pio_status_read),
        .frame_start      (frame_start),
        .line_swap        (line_swap),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .row_ready        (row_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic write_pixel(input int idx, input int data);
        int n;
        pio_pixel_index  = 16'(idx);
        pio_pixel_data   = 24'(data);
        pio_status_write = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pio_status_read[0] && n < 8);
        if (!pio_status_read[0]) check("ack_timeout", {31'd0, pio_status_read[0]}, 32'd1);
        pio_status_write = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (pio_status_read[0] && n < 8);
        if (pio_status_read[0]) check("ack_release_timeout", {31'd0, pio_status_read[0]}, 32'd0);
    endtask

    task automatic fill(input int row, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) write_pixel(i, (row << 16) | i);
    endtask

    task automatic pulse_swap();
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
    endtask

    initial begin
        rd_tab[0] = '{10'd37,   24'h000025};
        rd_tab[1] = '{10'd5,    24'hFF0000};
        rd_tab[2] = '{10'd0,    24'h000000};
        rd_tab[3] = '{10'd639,  24'h00027F};
        rd_tab[4] = '{10'd640,  24'h000000};
        rd_tab[5] = '{10'd1023, 24'h000000};
        rd_tab[6] = '{10'd100,  24'h000064};

        rst = 1'b1;
        pio_pixel_data = '0;
        pio_pixel_index = '0;
        pio_status_write = '0;
        frame_start = 1'b0;
        line_swap = 1'b0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        check("reset_status", {28'd0, pio_status_read}, 32'h0);
        check("reset_row", {16'd0, pio_pixel_row}, 32'h0);
        check("reset_row_ready", {31'd0, row_ready}, 32'h0);
        check("reset_rd_data", {8'd0, rd_data}, 32'h0);

        // frame start, then a single handshake
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("req_status", {28'd0, pio_status_read}, 32'h2);
        check("req_row", {16'd0, pio_pixel_row}, 32'h0);
        pio_pixel_index  = 16'd5;
        pio_pixel_data   = 24'hFF0000;
        pio_status_write = 4'b0001;
        tick();
        check("ack_set", {28'd0, pio_status_read}, 32'h3);
        pio_status_write = 4'b0000;
        tick();
        check("ack_clear", {28'd0, pio_status_read}, 32'h2);

        // remainder of row 0, then swap it to the front
        fill(0, 0, 4);
        fill(0, 6, 639);
        check("row0_ready", {31'd0, row_ready}, 32'h1);
        check("row0_full_status", {28'd0, pio_status_read}, 32'h0);
        pulse_swap();
        tick();
        check("row1_req", {16'd0, pio_pixel_row}, 32'd1);
        check("row1_status", {28'd0, pio_status_read}, 32'h2);
        check("row1_ready_clear", {31'd0, row_ready}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            rd_addr = rd_tab[i].addr;
            tick();
            check($sformatf("rd_tab[%0d]", i), {8'd0, rd_data}, {8'd0, rd_tab[i].exp});
        end

        // underrun on a partial row; front row is repeated
        fill(1, 0, 99);
        pulse_swap();
        check("underrun_set", {28'd0, pio_status_read}, 32'h6);
        rd_addr = 10'd37;
        tick();
        check("front_repeat", {8'd0, rd_data}, 32'h000025);
        pio_status_write = 4'b1000;
        tick();
        pio_status_write = 4'b0000;
        check("underrun_clear", {28'd0, pio_status_read}, 32'h2);
        line_swap = 1'b1;
        pio_status_write = 4'b1000;
        tick();
        line_swap = 1'b0;
        pio_status_write = 4'b0000;
        check("set_beats_clear", {31'd0, pio_status_read[2]}, 32'h1);
        pio_status_write = 4'b1000;
        tick();
        pio_status_write = 4'b0000;

        // out-of-range indices are acknowledged but not counted
        pio_pixel_index  = 16'd700;
        pio_pixel_data   = 24'h123456;
        pio_status_write = 4'b0001;
        tick();
        check("bad_idx_ack", {28'd0, pio_status_read}, 32'hB);
        pio_status_write = 4'b0000;
        tick();
        check("bad_idx_sticky", {28'd0, pio_status_read}, 32'hA);
        write_pixel(640, 24'h654321);
        fill(1, 100, 638);
        check("bad_not_counted", {31'd0, row_ready}, 32'h0);
        write_pixel(639, (1 << 16) | 639);
        check("row1_ready", {31'd0, row_ready}, 32'h1);
        pio_status_write = 4'b1000;
        tick();
        pio_status_write = 4'b0000;
        check("bad_clear", {28'd0, pio_status_read}, 32'h0);

        // frame_start during a handshake waits for VALID to drop
        rd_addr = 10'd37;
        pulse_swap();
        tick();
        check("row2_req", {16'd0, pio_pixel_row}, 32'd2);
        check("front_row1", {8'd0, rd_data}, 32'h010025);
        pio_pixel_index  = 16'd3;
        pio_pixel_data   = 24'h020003;
        pio_status_write = 4'b0001;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ack_held_fs", {31'd0, pio_status_read[0]}, 32'h1);
        tick();
        check("ack_held_fs2", {31'd0, pio_status_read[0]}, 32'h1);
        pio_status_write = 4'b0000;
        tick();
        check("ack_drop_fs", {31'd0, pio_status_read[0]}, 32'h0);
        check("row_before_restart", {16'd0, pio_pixel_row}, 32'd2);
        tick();
        check("row_restart", {16'd0, pio_pixel_row}, 32'd0);
        fill(0, 0, 638);
        check("count_restarted", {31'd0, row_ready}, 32'h0);
        write_pixel(639, 639);
        check("restart_row_ready", {31'd0, row_ready}, 32'h1);

        // walk the frame to the last row and wrap
        for (int r = 1; r < TB_ROWS; r++) begin
            pulse_swap();
            tick();
            check($sformatf("walk_row%0d", r), {16'd0, pio_pixel_row}, 32'(r));
            fill(r, 0, 639);
        end
        pulse_swap();
        tick();
        check("row_wrap", {16'd0, pio_pixel_row}, 32'd0);
        check("row_wrap_status", {28'd0, pio_status_read}, 32'h2);

        // simultaneous frame_start and line_swap: no underrun
        frame_start = 1'b1;
        line_swap   = 1'b1;
        tick();
        frame_start = 1'b0;
        line_swap   = 1'b0;
        tick();
        check("fs_beats_swap", {28'd0, pio_status_read}, 32'h2);

        // asynchronous reset mid-handshake
        rd_addr = 10'd37;
        tick();
        check("front_row3", {8'd0, rd_data}, 32'h030025);
        pio_pixel_index  = 16'd0;
        pio_pixel_data   = 24'hABCDEF;
        pio_status_write = 4'b0001;
        tick();
        check("pre_reset_ack", {31'd0, pio_status_read[0]}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_status", {28'd0, pio_status_read}, 32'h0);
        check("async_rd_data", {8'd0, rd_data}, 32'h0);
        check("async_row_ready", {31'd0, row_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pio_status_write = 4'b0000;
        repeat (4) tick();
        check("idle_no_req", {28'd0, pio_status_read}, 32'h0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("post_reset_req", {28'd0, pio_status_read}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
